// File: rtl/vga_timing_generator.sv
// VGA timing generator: programmable porches, sync widths and sync polarity.
// Ports: control_clock/control_reset/enable in; h_sync, v_sync, display_enable,
// pixel_x, pixel_y, line_start, frame_start out (test_rgb with VGA_TEST_PATTERN_EN).
module vga_timing_generator #(
  parameter int   H_VISIBLE    = 1024,
  parameter int   H_FRONT      = 24,
  parameter int   H_SYNC       = 136,
  parameter int   H_BACK       = 160,
  parameter int   V_VISIBLE    = 768,
  parameter int   V_FRONT      = 3,
  parameter int   V_SYNC       = 6,
  parameter int   V_BACK       = 29,
  parameter logic H_SYNC_POL   = 1'b0,
  parameter logic V_SYNC_POL   = 1'b0,
  parameter int   COUNTER_SIZE = 11
) (
  input  logic                    control_clock,
  input  logic                    control_reset,
  input  logic                    enable,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    display_enable,
  output logic [COUNTER_SIZE-1:0] pixel_x,
  output logic [COUNTER_SIZE-1:0] pixel_y,
  output logic                    line_start,
`ifdef VGA_TEST_PATTERN_EN
  output logic                    frame_start,
  output logic [11:0]             test_rgb
`else
  output logic                    frame_start
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

  localparam logic [COUNTER_SIZE-1:0] H_LAST = COUNTER_SIZE'(H_TOTAL - 1);
  localparam logic [COUNTER_SIZE-1:0] V_LAST = COUNTER_SIZE'(V_TOTAL - 1);
  localparam logic [COUNTER_SIZE-1:0] H_VIS  = COUNTER_SIZE'(H_VISIBLE);
  localparam logic [COUNTER_SIZE-1:0] V_VIS  = COUNTER_SIZE'(V_VISIBLE);
  localparam logic [COUNTER_SIZE-1:0] HS_BEG = COUNTER_SIZE'(H_VISIBLE + H_FRONT);
  localparam logic [COUNTER_SIZE-1:0] HS_END =
    COUNTER_SIZE'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COUNTER_SIZE-1:0] VS_BEG = COUNTER_SIZE'(V_VISIBLE + V_FRONT);
  localparam logic [COUNTER_SIZE-1:0] VS_END =
    COUNTER_SIZE'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  if ((64'd1 << COUNTER_SIZE) < 64'(MAX_TOTAL)) begin : g_bad_width
    $error("COUNTER_SIZE too small for H_TOTAL/V_TOTAL");
  end
  if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0)
  begin : g_bad_zero
    $error("porch, sync and visible parameters must be non-zero");
  end

  logic [COUNTER_SIZE-1:0] h_q, h_d;
  logic [COUNTER_SIZE-1:0] v_q, v_d;
  logic [COUNTER_SIZE-1:0] px_q, py_q;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic de_q, de_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (enable) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Outputs decode the next counter value so they line up with the
  // counter state registered on the same edge.
  always_comb begin
    hs_d = ((h_d >= HS_BEG) && (h_d <= HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vs_d = ((v_d >= VS_BEG) && (v_d <= VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    de_d = (h_d < H_VIS) && (v_d < V_VIS);
    ls_d = enable && (h_d == '0);
    fs_d = enable && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge control_clock or posedge control_reset) begin
    if (control_reset) begin
      h_q  <= H_LAST;
      v_q  <= V_LAST;
      px_q <= '0;
      py_q <= '0;
      hs_q <= ~H_SYNC_POL;
      vs_q <= ~V_SYNC_POL;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      // Strobes drop while frozen; levels hold.
      ls_q <= ls_d;
      fs_q <= fs_d;
      if (enable) begin
        h_q  <= h_d;
        v_q  <= v_d;
        px_q <= h_d;
        py_q <= v_d;
        hs_q <= hs_d;
        vs_q <= vs_d;
        de_q <= de_d;
      end
    end
  end

  assign h_sync         = hs_q;
  assign v_sync         = vs_q;
  assign display_enable = de_q;
  assign pixel_x        = px_q;
  assign pixel_y        = py_q;
  assign line_start     = ls_q;
  assign frame_start    = fs_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [COUNTER_SIZE-1:0] BAR_W = COUNTER_SIZE'(H_VISIBLE / 8);

  if ((H_VISIBLE % 8) != 0) begin : g_bad_bar
    $error("H_VISIBLE must be a multiple of 8");
  end

  logic [2:0]  bar_c;
  logic [11:0] rgb_q, rgb_d;

  // Bar i shows colour code 7-i: white first, black last.
  always_comb begin
    bar_c = 3'd7 - 3'(h_d / BAR_W);
    rgb_d = de_d ? {{4{bar_c[1]}}, {4{bar_c[2]}}, {4{bar_c[0]}}} : 12'h000;
  end

  always_ff @(posedge control_clock or posedge control_reset) begin
    if (control_reset) begin
      rgb_q <= 12'h000;
    end else if (enable) begin
      rgb_q <= rgb_d;
    end
  end

  assign test_rgb = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench for vga_timing_generator on a reduced raster.
// Linear-position model plus literal pins on counts, periods and edges.
module tb_vga_timing_generator;

  localparam int HV = 16, HF = 2, HS = 3, HB = 4;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 2;
  localparam int CS = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk, rst, en;
  logic hs, vs, de, ls, fs;
  logic [CS-1:0] px, py;
`ifdef VGA_TEST_PATTERN_EN
  logic [11:0] rgb;
`endif

  vga_timing_generator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .COUNTER_SIZE(CS)
  ) dut (
    .control_clock(clk),
    .control_reset(rst),
    .enable(en),
    .h_sync(hs),
    .v_sync(vs),
    .display_enable(de),
    .pixel_x(px),
    .pixel_y(py),
    .line_start(ls),
`ifdef VGA_TEST_PATTERN_EN
    .frame_start(fs),
    .test_rgb(rgb)
`else
    .frame_start(fs)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit check_en = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position along the raster as one linear index.
  int m_pos;
  int m_x, m_y, m_hs, m_vs, m_de, m_ls, m_fs, m_rgb;

  function automatic int pattern(int x);
    int c;
    c = 7 - x / (HV / 8);
    return ((c >> 1) & 1) * 12'hF00 + ((c >> 2) & 1) * 12'h0F0 + (c & 1) * 12'h00F;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos = FRAME - 1;
      m_x = 0; m_y = 0; m_hs = 1; m_vs = 1;
      m_de = 0; m_ls = 0; m_fs = 0; m_rgb = 0;
    end else if (en) begin
      m_pos = (m_pos + 1) % FRAME;
      m_x = m_pos % HT;
      m_y = m_pos / HT;
      m_hs = (m_x >= HV + HF && m_x < HV + HF + HS) ? 0 : 1;
      m_vs = (m_y >= VV + VF && m_y < VV + VF + VS) ? 0 : 1;
      m_de = (m_x < HV && m_y < VV) ? 1 : 0;
      m_ls = (m_x == 0) ? 1 : 0;
      m_fs = (m_pos == 0) ? 1 : 0;
      m_rgb = m_de ? pattern(m_x) : 0;
    end else begin
      m_ls = 0;
      m_fs = 0;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("pixel_x", int'(px), m_x);
      chk("pixel_y", int'(py), m_y);
      chk("h_sync", int'(hs), m_hs);
      chk("v_sync", int'(vs), m_vs);
      chk("display_enable", int'(de), m_de);
      chk("line_start", int'(ls), m_ls);
      chk("frame_start", int'(fs), m_fs);
`ifdef VGA_TEST_PATTERN_EN
      chk("test_rgb", int'(rgb), m_rgb);
`endif
    end
  end

  task automatic chk_reset_vals(string tag);
    chk({tag, "_x"}, int'(px), 0);
    chk({tag, "_y"}, int'(py), 0);
    chk({tag, "_de"}, int'(de), 0);
    chk({tag, "_hs"}, int'(hs), 1);
    chk({tag, "_vs"}, int'(vs), 1);
    chk({tag, "_ls"}, int'(ls), 0);
    chk({tag, "_fs"}, int'(fs), 0);
  endtask

  task automatic chk_first_edge(string tag);
    @(posedge clk);
    #1;
    chk({tag, "_x"}, int'(px), 0);
    chk({tag, "_y"}, int'(py), 0);
    chk({tag, "_de"}, int'(de), 1);
    chk({tag, "_ls"}, int'(ls), 1);
    chk({tag, "_fs"}, int'(fs), 1);
`ifdef VGA_TEST_PATTERN_EN
    chk({tag, "_rgb"}, int'(rgb), 12'hFFF);
`endif
  endtask

  initial begin
    int de_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt;
    int hs_edge_x, vs_edge_y, last_ls, ls_per, last_fs, fs_per;
    int prev_hs, prev_vs, cyc, found;

    rst = 1;
    en = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    check_en = 1;
    #2;
    rst = 0;
    en = 1;
    chk_first_edge("first");

    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0;
    hs_edge_x = -1; vs_edge_y = -1; last_ls = -1; ls_per = -1;
    last_fs = -1; fs_per = -1; prev_hs = 1; prev_vs = 1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      de_cnt += int'(de);
      hs_cnt += int'(!hs);
      vs_cnt += int'(!vs);
      if (ls) begin
        if (last_ls >= 0) ls_per = i - last_ls;
        last_ls = i;
        ls_cnt++;
      end
      if (fs) begin
        if (last_fs >= 0) fs_per = i - last_fs;
        last_fs = i;
        fs_cnt++;
      end
      if (prev_hs == 1 && !hs && hs_edge_x < 0) hs_edge_x = int'(px);
      if (prev_vs == 1 && !vs && vs_edge_y < 0) vs_edge_y = int'(py);
      prev_hs = int'(hs);
      prev_vs = int'(vs);
    end
    chk("de_cycles", de_cnt, 2 * 96);
    chk("hsync_low_cycles", hs_cnt, 2 * 11 * 3);
    chk("vsync_low_cycles", vs_cnt, 2 * 2 * 25);
    chk("hsync_start_x", hs_edge_x, 18);
    chk("vsync_start_y", vs_edge_y, 7);
    chk("line_start_count", ls_cnt, 22);
    chk("line_start_period", ls_per, 25);
    chk("frame_start_count", fs_cnt, 2);
    chk("frame_start_period", fs_per, 275);

    found = 0;
    for (cyc = 0; cyc < 2 * FRAME; cyc++) begin
      if (px == 5) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("found_x5", found, 1);
    en = 0;
    repeat (10) begin
      @(negedge clk);
      chk("pause_x", int'(px), 5);
      chk("pause_ls", int'(ls), 0);
    end
    en = 1;
    @(posedge clk);
    #1;
    chk("resume_x", int'(px), 6);

    found = 0;
    for (cyc = 0; cyc < 2 * FRAME; cyc++) begin
      @(negedge clk);
      if (px == 10 && py == 4) begin
        found = 1;
        break;
      end
    end
    chk("found_10_4", found, 1);
    #2;
    rst = 1;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    #2;
    rst = 0;
    chk_first_edge("rerun");

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) begin
        #2;
        rst = 1;
        #2;
        rst = 0;
      end
    end

    @(negedge clk);
    check_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
